// File: rtl/sram_mem_responder.sv
// MEM-stage data-memory responder: serves 32-bit loads/stores as two 16-bit
// halves on an external asynchronous SRAM, stalling the pipeline via ready.
module sram_mem_responder #(
  parameter logic [31:0] BASE_ADDR    = 32'd1024,
  parameter int unsigned PHASE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic        sram_ce_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [2:0] {StIdle, StRdLo, StRdHi, StWrLo, StWrHi, StDone} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [15:0] wdata_hi_q;
  logic [16:0] word;
  logic        phase_end;

  // Borrow is discarded and upper word bits are dropped: no range check.
  assign word      = 17'((address - BASE_ADDR) >> 2);
  assign phase_end = (cnt_q == 4'(PHASE_CYCLES - 1));

  assign ready = (state_q == StDone) | ((state_q == StIdle) & ~rd_en & ~wr_en);

  // Both byte lanes are always enabled once out of reset.
  assign sram_ub_n = rst;
  assign sram_lb_n = rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      wdata_hi_q  <= 16'd0;
      read_data   <= 32'd0;
      sram_addr   <= 18'd0;
      sram_dq_out <= 16'd0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_ce_n   <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_q <= 4'd0;
          if (wr_en) begin
            state_q     <= StWrLo;
            sram_addr   <= {word, 1'b0};
            sram_dq_out <= write_data[15:0];
            wdata_hi_q  <= write_data[31:16];
            sram_dq_oe  <= 1'b1;
            sram_ce_n   <= 1'b0;
            sram_we_n   <= 1'b0;
            sram_oe_n   <= 1'b1;
          end else if (rd_en) begin
            state_q    <= StRdLo;
            sram_addr  <= {word, 1'b0};
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b0;
          end
        end
        StRdLo: begin
          if (phase_end) begin
            read_data[15:0] <= sram_dq_in;
            sram_addr[0]    <= 1'b1;
            cnt_q           <= 4'd0;
            state_q         <= StRdHi;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StRdHi: begin
          if (phase_end) begin
            read_data[31:16] <= sram_dq_in;
            sram_ce_n        <= 1'b1;
            sram_oe_n        <= 1'b1;
            cnt_q            <= 4'd0;
            state_q          <= StDone;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StWrLo: begin
          if (phase_end) begin
            sram_addr[0] <= 1'b1;
            sram_dq_out  <= wdata_hi_q;
            cnt_q        <= 4'd0;
            state_q      <= StWrHi;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StWrHi: begin
          if (phase_end) begin
            sram_ce_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            cnt_q      <= 4'd0;
            state_q    <= StDone;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StDone: begin
          cnt_q   <= 4'd0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Bench for sram_mem_responder: directed and random loads/stores against an
// SRAM model, checked with a word-level reference memory.
module tb_sram_mem_responder;

  localparam int unsigned P = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n;

  logic        rd_en2;
  logic [31:0] address2, read_data2;
  logic        ready2;
  logic [17:0] sram_addr2;
  logic [15:0] sram_dq_out2, sram_dq_in2;
  logic        sram_dq_oe2, sram_we_n2, sram_oe_n2, sram_ce_n2, sram_ub_n2, sram_lb_n2;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [int unsigned];
  logic [31:0] last_read;

  bit [15:0]  sram [256];
  bit [255:0] written;

  always #5 clk = ~clk;

  sram_mem_responder #(.BASE_ADDR(32'd1024), .PHASE_CYCLES(P)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  sram_mem_responder #(.BASE_ADDR(32'd1024), .PHASE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en2), .wr_en(1'b0), .address(address2),
    .write_data(32'd0), .read_data(read_data2), .ready(ready2),
    .sram_addr(sram_addr2), .sram_dq_out(sram_dq_out2), .sram_dq_in(sram_dq_in2),
    .sram_dq_oe(sram_dq_oe2), .sram_we_n(sram_we_n2), .sram_oe_n(sram_oe_n2),
    .sram_ce_n(sram_ce_n2), .sram_ub_n(sram_ub_n2), .sram_lb_n(sram_lb_n2)
  );

  // Unwritten SRAM locations hold a fixed pattern of their low address byte.
  function automatic logic [15:0] dflt(input logic [17:0] h);
    return {h[7:0], h[7:0]} ^ 16'h5A3C;
  endfunction

  function automatic logic [31:0] ref_load(input logic [16:0] w);
    if (ref_mem.exists(int'(w))) return ref_mem[int'(w)];
    return {dflt({w, 1'b1}), dflt({w, 1'b0})};
  endfunction

  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n) begin
      sram[sram_addr[7:0]]    <= sram_dq_out;
      written[sram_addr[7:0]] <= 1'b1;
    end

  always_comb begin
    sram_dq_in = 16'h0000;
    if (!sram_ce_n && !sram_oe_n)
      sram_dq_in = written[sram_addr[7:0]] ? sram[sram_addr[7:0]] : dflt(sram_addr);
  end

  assign sram_dq_in2 = !sram_oe_n2 ? (sram_addr2[15:0] ^ 16'hC3C3) : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One full transfer: request driven just after an edge (cycle 0), then every
  // cycle through DONE is checked; inputs are released in the DONE cycle.
  task automatic do_xfer(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] wd);
    logic [16:0] w;
    logic [31:0] exp_rd;
    logic        hi;
    w = 17'((a - 32'd1024) >> 2);
    exp_rd = ref_load(w);
    if (wr) ref_mem[int'(w)] = wd;
    @(posedge clk); #1;
    rd_en = rd; wr_en = wr; address = a; write_data = wd;
    @(negedge clk);
    chk("c0_ready", {31'd0, ready}, 32'd0);
    for (int c = 1; c <= 2 * P; c++) begin
      @(negedge clk);
      hi = (c > P);
      chk("xfer_addr", {14'd0, sram_addr}, {14'd0, w, hi});
      chk("xfer_ready", {31'd0, ready}, 32'd0);
      chk("xfer_ce_n", {31'd0, sram_ce_n}, 32'd0);
      if (wr) begin
        chk("wr_we_n", {31'd0, sram_we_n}, 32'd0);
        chk("wr_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("wr_dq_oe", {31'd0, sram_dq_oe}, 32'd1);
        chk("wr_dq_out", {16'd0, sram_dq_out}, {16'd0, hi ? wd[31:16] : wd[15:0]});
      end else begin
        chk("rd_oe_n", {31'd0, sram_oe_n}, 32'd0);
        chk("rd_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rd_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
      end
    end
    @(negedge clk);
    chk("done_ready", {31'd0, ready}, 32'd1);
    chk("done_strobes", {28'd0, sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe}, 32'hE);
    if (!wr) last_read = exp_rd;
    chk("done_read_data", read_data, last_read);
    rd_en = 1'b0; wr_en = 1'b0; address = $urandom; write_data = $urandom;
  endtask

  initial begin
    rst = 1'b0; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
    rd_en2 = 1'b0; address2 = 32'd0; last_read = 32'd0;

    // Asynchronous reset applied between clock edges.
    #3 rst = 1'b1;
    #1;
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_addr", {14'd0, sram_addr}, 32'd0);
    chk("rst_dq_out", {16'd0, sram_dq_out}, 32'd0);
    chk("rst_strobes", {26'd0, sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n,
        sram_lb_n}, 32'h1F);
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, ready}, 32'd1);
    chk("post_rst_lanes", {30'd0, sram_ub_n, sram_lb_n}, 32'd0);
    chk("post_rst_ce_n", {31'd0, sram_ce_n}, 32'd1);

    do_xfer(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF);
    do_xfer(1'b1, 1'b0, 32'd1032, 32'h0);
    chk("load_deadbeef", read_data, 32'hDEADBEEF);

    // Both enables set: write wins; then a back-to-back load of the same word.
    do_xfer(1'b1, 1'b1, 32'd1100, 32'h1234ABCD);
    do_xfer(1'b1, 1'b0, 32'd1101, 32'h0);
    chk("prio_load", read_data, 32'h1234ABCD);

    // Address below the base wraps to the top of the half-word space.
    do_xfer(1'b1, 1'b0, 32'd1020, 32'h0);

    // Single-cycle phases on the second instance.
    @(posedge clk); #1 rd_en2 = 1'b1; address2 = 32'd1024;
    @(negedge clk);
    chk("p1_c0_ready", {31'd0, ready2}, 32'd0);
    @(negedge clk);
    chk("p1_c1_addr", {14'd0, sram_addr2}, 32'd0);
    chk("p1_c1_oe_n", {31'd0, sram_oe_n2}, 32'd0);
    chk("p1_c1_ready", {31'd0, ready2}, 32'd0);
    @(negedge clk);
    chk("p1_c2_addr", {14'd0, sram_addr2}, 32'd1);
    chk("p1_c2_ready", {31'd0, ready2}, 32'd0);
    @(negedge clk);
    chk("p1_c3_ready", {31'd0, ready2}, 32'd1);
    chk("p1_c3_data", read_data2, 32'hC3C2C3C3);
    rd_en2 = 1'b0;

    // Reset during the high half of a store.
    @(posedge clk); #1 wr_en = 1'b1; address = 32'd1424; write_data = $urandom;
    repeat (4) @(negedge clk);
    chk("mid_we_n_before", {31'd0, sram_we_n}, 32'd0);
    chk("mid_addr_before", {14'd0, sram_addr}, 32'd201);
    #1 rst = 1'b1;
    #1;
    chk("mid_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("mid_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("mid_ce_n", {31'd0, sram_ce_n}, 32'd1);
    chk("mid_addr", {14'd0, sram_addr}, 32'd0);
    last_read = 32'd0;
    wr_en = 1'b0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_idle_ce_n", {31'd0, sram_ce_n}, 32'd1);
    chk("mid_idle_ready", {31'd0, ready}, 32'd1);
    do_xfer(1'b1, 1'b0, 32'd1032, 32'h0);
    do_xfer(1'b0, 1'b1, 32'd1036, 32'hCAFEF00D);

    // Random traffic over a small window so loads hit earlier stores.
    repeat (24) begin
      int unsigned op, w, gap;
      op  = $urandom_range(0, 2);
      w   = $urandom_range(0, 63);
      gap = $urandom_range(0, 2);
      do_xfer(op != 1, op != 0, 32'd1024 + w * 4 + $urandom_range(0, 3), $urandom);
      repeat (gap) begin
        @(negedge clk);
        chk("gap_ready", {31'd0, ready}, 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
